// File: rtl/dmem_responder_if.sv
// Load/store handshake bundle between the MEM stage (master) and the data-memory responder (slave).
interface dmem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory responder: byte/half/word loads and read-modify-write stores on a word-wide sync RAM.
// Optional macro MISALIGN_TRAP_EN turns misaligned requests into an immediate error response.
module dmem_responder #(
  parameter int ADDR_W = 14
) (
  input  logic              clk_cpu,
  input  logic              rst,
  dmem_responder_if.slave   bus
);

  typedef enum logic [2:0] {IDLE, READ, WAIT, WRITE, RESP} state_t;

  state_t              state;
  logic                ready_q;
  logic                valid_q;
  logic                err_q;
  logic [31:0]         rdata_q;
  logic                lat_we;
  logic                lat_uns;
  logic [1:0]          lat_size;
  logic [1:0]          byte_off;
  logic [ADDR_W-1:0]   word_idx;
  logic [31:0]         wr_word;
  logic [31:0]         ram_q;
  logic [31:0]         mem [0:(1<<ADDR_W)-1];
  logic                accept;
  logic                trap;
  logic [7:0]          sel_byte;
  logic [15:0]         sel_half;
  logic [31:0]         load_data;
  logic [31:0]         merged;

  assign accept = bus.req_valid && ready_q;

`ifdef MISALIGN_TRAP_EN
  assign trap = (bus.req_size == 2'b01 && bus.req_addr[0]) ||
                (bus.req_size[1] && bus.req_addr[1:0] != 2'b00);
`else
  assign trap = 1'b0;
`endif

  assign bus.req_ready  = ready_q;
  assign bus.resp_valid = valid_q;
  assign bus.resp_rdata = rdata_q;
  assign bus.resp_err   = err_q;

  always_comb begin
    sel_byte  = ram_q[{byte_off, 3'b000} +: 8];
    sel_half  = byte_off[1] ? ram_q[31:16] : ram_q[15:0];
    load_data = ram_q;
    merged    = ram_q;
    case (lat_size)
      2'b00: begin
        load_data = {{24{~lat_uns & sel_byte[7]}}, sel_byte};
        merged[{byte_off, 3'b000} +: 8] = wr_word[7:0];
      end
      2'b01: begin
        load_data = {{16{~lat_uns & sel_half[15]}}, sel_half};
        if (byte_off[1]) merged[31:16] = wr_word[15:0];
        else             merged[15:0]  = wr_word[15:0];
      end
      default: begin
        load_data = ram_q;
        merged    = wr_word;
      end
    endcase
  end

  // The write is gated by rst so a reset landing on the WRITE edge abandons the store.
  always_ff @(posedge clk_cpu) begin
    if (state == READ) ram_q <= mem[word_idx];
    if (state == WRITE && !rst) mem[word_idx] <= wr_word;
  end

  always_ff @(posedge clk_cpu) begin
    if (rst) begin
      state   <= IDLE;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= 32'h0;
    end else begin
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            lat_we   <= bus.req_we;
            lat_uns  <= bus.req_unsigned;
            lat_size <= bus.req_size;
            byte_off <= bus.req_addr[1:0];
            word_idx <= bus.req_addr[ADDR_W+1:2];
            wr_word  <= bus.req_wdata;
            ready_q  <= 1'b0;
            if (trap) begin
              state   <= RESP;
              valid_q <= 1'b1;
              err_q   <= 1'b1;
              rdata_q <= 32'h0;
            end else if (bus.req_we && bus.req_size[1]) begin
              state <= WRITE;
            end else begin
              state <= READ;
            end
          end
        end
        READ: state <= WAIT;
        WAIT: begin
          if (lat_we) begin
            wr_word <= merged;
            state   <= WRITE;
          end else begin
            rdata_q <= load_data;
            valid_q <= 1'b1;
            state   <= RESP;
          end
        end
        WRITE: begin
          valid_q <= 1'b1;
          state   <= RESP;
        end
        RESP: begin
          ready_q <= 1'b1;
          state   <= IDLE;
        end
        default: begin
          ready_q <= 1'b1;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule
